// File: rtl/reg_file_2r1w.sv
// miniRISC architectural register file: 2**ADDR_W x DATA_W, two combinational
// read ports, one synchronous write port, optional same-cycle write-to-read bypass.
module reg_file_2r1w #(
    parameter int unsigned         DATA_W   = 32,
    parameter int unsigned         ADDR_W   = 5,
    parameter bit                  BYPASS   = 1'b1,
    parameter int unsigned         SP_INDEX = 29,
    parameter logic [DATA_W-1:0]   SP_RESET = 32'h0000_03FC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_live;
    logic              rs_hit;
    logic              rt_hit;

    // Entry 0 is reset to zero and never written, so it stays hardwired to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // A write only forwards while out of reset, since reset discards it.
    assign wr_live = rst && wr_en && (wr_addr != '0);
    assign rs_hit  = BYPASS && wr_live && (wr_addr == rs_addr);
    assign rt_hit  = BYPASS && wr_live && (wr_addr == rt_addr);

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (rs_hit) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (rt_hit) begin
            rt_data = wr_data;
        end
    end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Architectural register file for the miniRISC datapath, directly downstream of the 3:1 write-destination selector in decode/writeback.
- The selector's 5-bit output drives this block's write address (rt, rd or the link register).
- Provides two combinational read ports for the ALU/branch operands and one synchronous write port.
- Includes optional same-cycle write-to-read bypass.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = read returns the stored value
SP_INDEX, 29, index of the stack-pointer register
SP_RESET, 32'h0000_03FC, value loaded into register SP_INDEX on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
rs_addr  input  ADDR_W  read port A index
rt_addr  input  ADDR_W  read port B index
rs_data  output  DATA_W  read port A data
rt_data  output  DATA_W  read port B data
wr_en  input  1  write enable for the write port
wr_addr  input  ADDR_W  write index (output of the destination-select mux)
wr_data  input  DATA_W  write data (writeback result or PC+4 for link)

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits each. Register 0 is hardwired to zero.
- Reset: rst low asynchronously clears every register to 0, except register SP_INDEX, which loads SP_RESET. Reset takes effect immediately, with no clock needed.
- While rst is low:
  - writes are ignored;
  - rs_data and rt_data show the reset contents (0, or SP_RESET when the index is SP_INDEX).
- Reset release: the first write is accepted on the first rising clk edge on which rst is high.
- Reset asserted in the same cycle as a write: the write is lost and reset wins.
- Write: on rising clk, if rst is high, wr_en is 1 and wr_addr != 0, then reg[wr_addr] <= wr_data.
  - wr_addr = 0 is a silent no-op; no other register changes.
  - Write latency is 1 cycle; the stored value is visible from the next cycle.
- Read: rs_data and rt_data are purely combinational from the addresses and state, with zero latency.
  - rs_addr == 0 gives 0; likewise rt_addr == 0 gives 0 (also with bypass on).
  - With BYPASS=1, a read returns wr_data in the same cycle when all of the following hold:
    - wr_en = 1;
    - wr_addr = read address;
    - wr_addr != 0;
    - rst = 1.
  - With BYPASS=0, a read returns the stored (old) value until the edge.
- Both read ports may address the same register, and either may match the write address. Each port resolves bypass independently.
- No width conversion: wr_data is stored bit-exact and reads are never sign- or zero-extended.
- No hazards or stalls are generated here; pipeline hazard control belongs to the forwarding unit.
- Unknown or X addresses are not sanitised. The bench must not drive X on addresses when rst is high.

Test Plan:
- Reset contents: pulse rst low mid-cycle with no clk edge -> outputs update immediately. Then sweep rs_addr 0..31 -> rs_data = 0 everywhere except index 29, which reads 32'h0000_03FC.
- Basic write/read: write reg 5 = 32'hDEAD_BEEF and reg 31 = 32'h0000_0040 (link) on consecutive cycles. Then rs_addr=5, rt_addr=31 -> 32'hDEAD_BEEF and 32'h0000_0040.
- Register-zero protection: wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF -> rs_addr=0 reads 0, both during the write cycle and after it. Registers 1..31 are unchanged.
- Bypass (BYPASS=1):
  - Set reg 7 = 32'h1111_1111.
  - Next cycle drive wr_en=1, wr_addr=7, wr_data=32'h2222_2222 with rs_addr=rt_addr=7 -> both ports read 32'h2222_2222 in the same cycle.
  - With BYPASS=0 the same stimulus reads 32'h1111_1111 until the edge, then 32'h2222_2222.
- Reset collision: assert rst low in the same cycle as wr_en=1, wr_addr=9, wr_data=32'hABCD_0123 -> after release, reg 9 reads 0. A write on the first edge after release (reg 9 = 32'h5) is stored.
- Random regression: 2000 cycles of random wr_en/wr_addr/wr_data and read addresses checked against a reference array model. Include bursts of wr_en=0 -> zero mismatches.
